// File: rtl/square_motion_pkg.sv
// Shared types for the square motion controller: FSM states, fixed-point
// position/speed types, a debug snapshot struct and saturating speed helpers.
package square_motion_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_UPD_X = 2'd2,
    ST_UPD_Y = 2'd3
  } motion_state_e;

  localparam int FRAC_BITS = 4;
  localparam int POS_W     = 16;
  localparam int SPEED_W   = 8;
  localparam int PIX_W     = 11;

  typedef logic signed [POS_W-1:0]   pos_q11_4_t;
  typedef logic signed [SPEED_W-1:0] speed_t;

  localparam speed_t SPEED_MAX = 8'sh7f;
  localparam speed_t SPEED_MIN = 8'sh80;

  typedef struct packed {
    motion_state_e state;
    logic          col_x;
    logic          col_y;
    speed_t        speed_x;
    speed_t        speed_y;
  } motion_dbg_t;

  // Two's-complement negation of -128 would wrap back to -128.
  function automatic speed_t sat_neg(input speed_t s);
    speed_t r;
    if (s == SPEED_MIN) r = SPEED_MAX;
    else                r = -s;
    return r;
  endfunction

  function automatic speed_t sat_abs(input speed_t s);
    speed_t r;
    if (s[SPEED_W-1]) r = sat_neg(s);
    else              r = s;
    return r;
  endfunction

  function automatic speed_t sat_add(input speed_t a, input speed_t b);
    logic signed [SPEED_W:0] sum;
    speed_t                  r;
    sum = {a[SPEED_W-1], a} + {b[SPEED_W-1], b};
    if (sum > 9'sd127)       r = SPEED_MAX;
    else if (sum < -9'sd128) r = SPEED_MIN;
    else                     r = sum[SPEED_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/square_motion_ctrl_axis_bounce.sv
// One-axis position step with wall bounce and collision reversal.
// Purely combinational; the controller registers new_pos/new_speed.
module axis_bounce
  import square_motion_pkg::*;
(
  input  pos_q11_4_t       pos,
  input  speed_t           speed,
  input  logic             col_flag,
  input  logic [PIX_W-1:0] size,
  input  logic [PIX_W-1:0] bound,
  output pos_q11_4_t       new_pos,
  output speed_t           new_speed
);

  localparam int CW = 19;

  speed_t                sx;
  speed_t                mag;
  logic signed [CW-1:0]  nx;
  logic signed [CW-1:0]  far_edge;
  logic signed [CW-1:0]  limit;
  logic [PIX_W-1:0]      span;

  assign sx       = col_flag ? sat_neg(speed) : speed;
  assign mag      = sat_abs(sx);
  assign nx       = {{(CW-POS_W){pos[POS_W-1]}}, pos} + {{(CW-SPEED_W){sx[SPEED_W-1]}}, sx};
  assign far_edge = nx + $signed({4'b0000, size, 4'b0000});
  assign limit    = $signed({4'b0000, bound, 4'b0000});
  assign span     = bound - size;

  // Clamping to the wall keeps the object fully on screen even when the
  // step would overshoot by a fraction of the speed.
  always_comb begin
    new_pos   = nx[POS_W-1:0];
    new_speed = sx;
    if (nx < 0) begin
      new_pos   = '0;
      new_speed = mag;
    end else if (far_edge > limit) begin
      new_pos   = {1'b0, span, 4'b0000};
      new_speed = -mag;
    end
  end

endmodule

// File: rtl/square_motion_ctrl.sv
// Per-frame motion controller for a rectangular object: owns position and
// velocity, bounces off screen edges and reverses on collision reports.
module square_motion_ctrl
  import square_motion_pkg::*;
#(
  parameter int OBJECT_WIDTH_X  = 100,
  parameter int OBJECT_HEIGHT_Y = 100,
  parameter int INITIAL_X       = 280,
  parameter int INITIAL_Y       = 185,
  parameter int INITIAL_SPEED_X = 32,
  parameter int INITIAL_SPEED_Y = -16,
  parameter int Y_ACCEL         = 0,
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic                    start,
  input  logic                    enable,
  input  logic                    collisionX,
  input  logic                    collisionY,
  output logic signed [PIX_W-1:0] topLeftX,
  output logic signed [PIX_W-1:0] topLeftY,
  output logic                    moving,
  output motion_dbg_t             dbg_o
);

  localparam pos_q11_4_t INIT_POS_X = pos_q11_4_t'(INITIAL_X << FRAC_BITS);
  localparam pos_q11_4_t INIT_POS_Y = pos_q11_4_t'(INITIAL_Y << FRAC_BITS);
  localparam speed_t     INIT_SPD_X = speed_t'(INITIAL_SPEED_X);
  localparam speed_t     INIT_SPD_Y = speed_t'(INITIAL_SPEED_Y);
  localparam speed_t     ACCEL_Y    = speed_t'(Y_ACCEL);

  motion_state_e            state_q;
  pos_q11_4_t               pos_x_q;
  pos_q11_4_t               pos_y_q;
  speed_t                   speed_x_q;
  speed_t                   speed_y_q;
  logic                     col_x_q;
  logic                     col_y_q;
  logic signed [PIX_W-1:0]  top_left_x_q;
  logic signed [PIX_W-1:0]  top_left_y_q;
  logic                     moving_q;

  pos_q11_4_t               pos_x_d;
  pos_q11_4_t               pos_y_d;
  speed_t                   speed_x_d;
  speed_t                   speed_y_d;
  speed_t                   speed_y_base;

  logic                     unused_pos_msb;

  // Gravity is folded in before the collision negation in axis_bounce.
  assign speed_y_base = sat_add(speed_y_q, ACCEL_Y);

  axis_bounce u_axis_x (
    .pos       (pos_x_q),
    .speed     (speed_x_q),
    .col_flag  (col_x_q),
    .size      (PIX_W'(OBJECT_WIDTH_X)),
    .bound     (PIX_W'(SCREEN_W)),
    .new_pos   (pos_x_d),
    .new_speed (speed_x_d)
  );

  axis_bounce u_axis_y (
    .pos       (pos_y_q),
    .speed     (speed_y_base),
    .col_flag  (col_y_q),
    .size      (PIX_W'(OBJECT_HEIGHT_Y)),
    .bound     (PIX_W'(SCREEN_H)),
    .new_pos   (pos_y_d),
    .new_speed (speed_y_d)
  );

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q      <= ST_IDLE;
      pos_x_q      <= INIT_POS_X;
      pos_y_q      <= INIT_POS_Y;
      speed_x_q    <= INIT_SPD_X;
      speed_y_q    <= INIT_SPD_Y;
      col_x_q      <= 1'b0;
      col_y_q      <= 1'b0;
      top_left_x_q <= PIX_W'(INITIAL_X);
      top_left_y_q <= PIX_W'(INITIAL_Y);
      moving_q     <= 1'b0;
    end else begin
      top_left_x_q <= pos_x_q[FRAC_BITS +: PIX_W];
      top_left_y_q <= pos_y_q[FRAC_BITS +: PIX_W];

      if (state_q != ST_IDLE) begin
        if (collisionX) col_x_q <= 1'b1;
        if (collisionY) col_y_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q  <= ST_RUN;
            moving_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (startOfFrame && enable) state_q <= ST_UPD_X;
        end
        // A collision pulse landing on the update cycle itself survives
        // into the next frame rather than being lost by the clear.
        ST_UPD_X: begin
          pos_x_q   <= pos_x_d;
          speed_x_q <= speed_x_d;
          col_x_q   <= collisionX;
          state_q   <= ST_UPD_Y;
        end
        ST_UPD_Y: begin
          pos_y_q   <= pos_y_d;
          speed_y_q <= speed_y_d;
          col_y_q   <= collisionY;
          state_q   <= ST_RUN;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign unused_pos_msb = ^{pos_x_q[POS_W-1], pos_y_q[POS_W-1]};

  assign topLeftX = top_left_x_q;
  assign topLeftY = top_left_y_q;
  assign moving   = moving_q;

  assign dbg_o.state   = state_q;
  assign dbg_o.col_x   = col_x_q;
  assign dbg_o.col_y   = col_y_q;
  assign dbg_o.speed_x = speed_x_q;
  assign dbg_o.speed_y = speed_y_q;

endmodule
